ram_arb_2to1: RTL and testbench

//   Two-requester arbiter/sequencer for the 128x8 single-port RAM. Port 0 (CPU)
//   and port 1 (DMA/peripheral) each issue single-beat read/write requests.
//   The block grants one port per cycle and drives the RAM en/we/addr/wdata pins.
//   It registers read data back to the granted port.

---
 rtl/ram_arb_2to1.sv | 170 +++++++++++++++++
 tb/tb_ram_arb_2to1.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_2to1
// Description : Two-requester arbiter/sequencer in front of a single-port
//               RAM. Port 0 (CPU) and port 1 (DMA/peripheral) issue
//               single-beat read/write requests; one port is granted per
//               cycle with round-robin fairness and an optional bounded lock
//               tenure for short bursts. Read data is registered back to the
//               port that was granted.
// Ports       : clk, rst                     clock, synchronous active-high reset
//               pN_req/we/addr/wdata/lock    request side of port N (N = 0,1)
//               pN_gnt                       combinational grant (beat done this cycle)
//               pN_rvalid/rdata              registered read return
//               ram_en/we/addr/wdata         RAM pins (zero when nothing granted)
//               ram_rdata                    RAM read data, combinational from ram_addr
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_2to1 #(
    parameter int AW       = 7,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p0_lock,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int   c_cnt_w   = $clog2(MAX_LOCK + 1);
    localparam logic c_lock_en = (MAX_LOCK > 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last;      // port granted most recently; the other wins a tie
    logic [c_cnt_w-1:0] r_lock_cnt;  // beats already granted in the current tenure

    logic w_arb_p0;
    logic w_arb_p1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_cnt_room;

    // Plain round-robin pick between the two requesters.
    assign w_arb_p0 = p0_req & (~p1_req | r_last);
    assign w_arb_p1 = p1_req & (~p0_req | ~r_last);

    // Another beat fits in the tenure if the count after this beat stays below MAX_LOCK.
    assign w_cnt_room = ((32'(r_lock_cnt) + 32'd1) < 32'(MAX_LOCK));

    // Grants are purely combinational. A lock owner that stops requesting hands
    // the cycle straight to the other port so no idle bubble appears. Reset
    // suppresses every grant, which keeps a mid-burst write off the RAM.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                S_LOCK0: begin
                    w_gnt0 = p0_req;
                    w_gnt1 = ~p0_req & p1_req;
                end
                S_LOCK1: begin
                    w_gnt1 = p1_req;
                    w_gnt0 = ~p1_req & p0_req;
                end
                default: begin
                    w_gnt0 = w_arb_p0;
                    w_gnt1 = w_arb_p1;
                end
            endcase
        end
    end

    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign ram_en    = w_gnt0 | w_gnt1;
    assign ram_we    = (w_gnt0 & p0_we) | (w_gnt1 & p1_we);
    assign ram_addr  = w_gnt0 ? p0_addr  : (w_gnt1 ? p1_addr  : '0);
    assign ram_wdata = w_gnt0 ? p0_wdata : (w_gnt1 ? p1_wdata : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            // Read return: capture the RAM word at the edge that completes the read.
            p0_rvalid <= w_gnt0 & ~p0_we;
            p1_rvalid <= w_gnt1 & ~p1_we;
            if (w_gnt0 && !p0_we) begin
                p0_rdata <= ram_rdata;
            end
            if (w_gnt1 && !p1_we) begin
                p1_rdata <= ram_rdata;
            end

            if (w_gnt0 && r_state == S_LOCK0) begin
                // Continuing port 0 tenure.
                r_last <= 1'b0;
                if (p0_lock && w_cnt_room) begin
                    r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
                end else begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                end
            end else if (w_gnt1 && r_state == S_LOCK1) begin
                // Continuing port 1 tenure.
                r_last <= 1'b1;
                if (p1_lock && w_cnt_room) begin
                    r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
                end else begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                end
            end else if (w_gnt0) begin
                // Fresh grant: from idle, or a handover out of a port 1 tenure.
                r_last <= 1'b0;
                if (p0_lock && c_lock_en) begin
                    r_state    <= S_LOCK0;
                    r_lock_cnt <= c_cnt_w'(1);
                end else begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                end
            end else if (w_gnt1) begin
                r_last <= 1'b1;
                if (p1_lock && c_lock_en) begin
                    r_state    <= S_LOCK1;
                    r_lock_cnt <= c_cnt_w'(1);
                end else begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                end
            end else begin
                r_state    <= S_IDLE;
                r_lock_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arb_2to1
// Description : Self-checking bench for ram_arb_2to1. A behavioural RAM sits
//               on the RAM pins; a tenure-based reference model predicts the
//               grant and RAM bus each cycle and queues expected read data,
//               which a separate monitor pops when rvalid is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arb_2to1;

    localparam int AW       = 7;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int checks   = 0;
    int failures = 0;

    txn_t       txq [2][$];       // pending transactions per port
    logic [7:0] sbq [2][$];       // expected read data per port
    int         trace [$];        // per-cycle {p1_gnt,p0_gnt}
    logic       rst_at_edge = 1'b1;

    logic [DW-1:0] mem    [128] = '{default: 8'h00};
    logic [DW-1:0] shadow [128] = '{default: 8'h00};

    always #5 clk = ~clk;

    ram_arb_2to1 #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Behavioural 128x8 single-port RAM.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic we, input int addr, input int wdata, input logic lock);
        txn_t t;
        t.we = we; t.addr = AW'(addr); t.wdata = DW'(wdata); t.lock = lock;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int a;
        case ($urandom_range(0, 5))
            0:       a = 0;
            1:       a = 127;
            2:       a = 1;
            3:       a = 126;
            default: a = int'($urandom_range(60, 75));
        endcase
        return mk(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 255)),
                  $urandom_range(0, 2) == 0);
    endfunction

    // ---------------- driver: presents queue heads, pops on grant ----------------
    initial begin : driver
        int   w0, w1;
        logic g0, g1;
        txn_t t;
        w0 = 0; w1 = 0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_lock = 0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
        forever begin
            @(negedge clk);
            g0 = p0_gnt; g1 = p1_gnt;
            @(posedge clk); #1;
            if (rst) begin
                txq[0].delete(); txq[1].delete(); w0 = 0; w1 = 0;
            end else begin
                if (p0_req && g0) begin txq[0].delete(0); w0 = 0; end
                else if (p0_req) begin
                    w0++;
                    if (w0 > 40) begin
                        checks++; failures++;
                        $display("FAIL p0_wait_bound: waited %0d cycles without grant", w0);
                        txq[0].delete(0); w0 = 0;
                    end
                end
                if (p1_req && g1) begin txq[1].delete(0); w1 = 0; end
                else if (p1_req) begin
                    w1++;
                    if (w1 > 40) begin
                        checks++; failures++;
                        $display("FAIL p1_wait_bound: waited %0d cycles without grant", w1);
                        txq[1].delete(0); w1 = 0;
                    end
                end
            end
            if (txq[0].size() != 0) begin
                t = txq[0][0];
                p0_req = 1; p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata; p0_lock = t.lock;
            end else begin
                p0_req = 0; p0_lock = 0;
            end
            if (txq[1].size() != 0) begin
                t = txq[1][0];
                p1_req = 1; p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata; p1_lock = t.lock;
            end else begin
                p1_req = 0; p1_lock = 0;
            end
        end
    end

    // ---------------- reference model: who owns the RAM this cycle ----------------
    // owner = port holding a lock tenure (-1 none); prio = port that wins a tie.
    initial begin : model
        int          owner, prio, beats, g;
        logic        c0, c1, lk, we;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [19:0] exp_bus, act_bus;
        owner = -1; prio = 0; beats = 0;
        forever begin
            @(negedge clk);
            g = -1;
            if (!rst) begin
                if (owner == 0 && p0_req) g = 0;
                else if (owner == 1 && p1_req) g = 1;
                else begin
                    c0 = p0_req && owner != 0;
                    c1 = p1_req && owner != 1;
                    if (c0 && c1) g = prio;
                    else if (c0) g = 0;
                    else if (c1) g = 1;
                end
            end
            exp_bus = '0;
            if (g == 0) exp_bus = {1'b1, 1'b0, 1'b1, p0_we, p0_addr, p0_wdata};
            if (g == 1) exp_bus = {1'b0, 1'b1, 1'b1, p1_we, p1_addr, p1_wdata};
            act_bus = {p0_gnt, p1_gnt, ram_en, ram_we, ram_addr, ram_wdata};
            check("gnt_ram_bus", 32'(act_bus), 32'(exp_bus));
            trace.push_back(int'({p1_gnt, p0_gnt}));

            if (rst) begin
                owner = -1; prio = 0; beats = 0;
            end else if (g >= 0) begin
                lk = (g == 0) ? p0_lock  : p1_lock;
                we = (g == 0) ? p0_we    : p1_we;
                a  = (g == 0) ? p0_addr  : p1_addr;
                d  = (g == 0) ? p0_wdata : p1_wdata;
                if (g == owner) begin
                    beats++;
                    if (!(lk && beats < MAX_LOCK)) owner = -1;
                end else begin
                    beats = 1;
                    owner = (lk && MAX_LOCK > 1) ? g : -1;
                end
                prio = 1 - g;
                if (we) shadow[a] = d;
                else    sbq[g].push_back(shadow[a]);
            end else begin
                owner = -1; beats = 0;
            end
            rst_at_edge = rst;
        end
    end

    // ---------------- monitor: registered read return ----------------
    initial begin : monitor
        logic [7:0] last [2];
        logic       exp_rv;
        last[0] = 8'h00; last[1] = 8'h00;
        forever begin
            @(posedge clk); #2;
            for (int n = 0; n < 2; n++) begin
                exp_rv = (sbq[n].size() != 0) && !rst_at_edge;
                if (rst_at_edge) begin
                    last[n] = 8'h00;
                    sbq[n].delete();
                end else if (sbq[n].size() != 0) begin
                    last[n] = sbq[n].pop_front();
                end
                if (n == 0) begin
                    check("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv));
                    check("p0_rdata", 32'(p0_rdata), 32'(last[0]));
                end else begin
                    check("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv));
                    check("p1_rdata", 32'(p1_rdata), 32'(last[1]));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((txq[0].size() != 0 || txq[1].size() != 0 || p0_req || p1_req) && n < 200) begin
            @(posedge clk); #3;
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL idle_timeout: requests still pending after %0d cycles", n);
        end
        repeat (3) begin @(posedge clk); #3; end
    endtask

    // Compare the grant trace from the first grant at/after 'from' (1 = p0, 2 = p1).
    task automatic check_seq(input string nm, input int from, input int exp[$]);
        int idx;
        idx = -1;
        for (int i = from; i < trace.size(); i++) begin
            if (trace[i] != 0) begin idx = i; break; end
        end
        if (idx < 0) begin
            checks++; failures++;
            $display("FAIL %s: no grant seen, expected first %0d", nm, exp[0]);
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                check(nm, (idx + i < trace.size()) ? trace[idx + i] : -1, exp[i]);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        int         mark;
        int         exp_q [$];
        logic [7:0] pre41;
        int         n;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #3;
        check("rst_outputs", {p0_rvalid, p1_rvalid, p0_rdata, p1_rdata}, 32'h0);
        check("rst_ram_en_idle", 32'(ram_en), 32'h0);

        // p0 write 5 = A5, then p1 read 5.
        txq[0].push_back(mk(1, 5, 8'hA5, 0));
        wait_idle();
        check("mem5_written", 32'(mem[5]), 32'hA5);
        txq[1].push_back(mk(0, 5, 0, 0));
        wait_idle();
        check("p1_read_a5", 32'(p1_rdata), 32'hA5);

        // Both ports requesting without lock: strict alternation starting at p0.
        mark = trace.size();
        for (int i = 0; i < 3; i++) begin
            txq[0].push_back(mk(0, i, 0, 0));
            txq[1].push_back(mk(0, 3 + i, 0, 0));
        end
        wait_idle();
        exp_q = {1, 2, 1, 2, 1, 2};
        check_seq("rr_alternate", mark, exp_q);

        // p0 locks continuously against a waiting p1: capped at MAX_LOCK beats.
        mark = trace.size();
        for (int i = 0; i < 6; i++) txq[0].push_back(mk(1, 10 + i, 8'h50 + i, 1));
        txq[1].push_back(mk(0, 10, 0, 0));
        txq[1].push_back(mk(0, 11, 0, 0));
        wait_idle();
        exp_q = {1, 1, 1, 1, 2, 1, 1, 2};
        check_seq("lock_cap", mark, exp_q);

        // p0 locks 2 beats then drops: p1 follows with no idle cycle.
        mark = trace.size();
        txq[0].push_back(mk(0, 12, 0, 1));
        txq[0].push_back(mk(1, 20, 8'h77, 1));
        txq[1].push_back(mk(0, 20, 0, 0));
        wait_idle();
        exp_q = {1, 1, 2};
        check_seq("lock_handover", mark, exp_q);
        check("p1_sees_lock_write", 32'(p1_rdata), 32'h77);

        // Boundary addresses.
        txq[0].push_back(mk(1, 127, 8'h3C, 0));
        txq[0].push_back(mk(1, 0, 8'hC3, 0));
        txq[0].push_back(mk(0, 127, 0, 0));
        wait_idle();
        check("rd_addr127", 32'(p0_rdata), 32'h3C);
        txq[0].push_back(mk(0, 0, 0, 0));
        wait_idle();
        check("rd_addr0", 32'(p0_rdata), 32'hC3);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #3;
            if (txq[0].size() < 2 && $urandom_range(0, 2) == 0) txq[0].push_back(rand_txn());
            if (txq[1].size() < 2 && $urandom_range(0, 2) == 0) txq[1].push_back(rand_txn());
        end
        wait_idle();

        // Reset in the middle of a p1 locked write burst.
        pre41 = mem[41];
        txq[1].push_back(mk(1, 40, 8'h11, 1));
        txq[1].push_back(mk(1, 41, 8'h22, 1));
        txq[1].push_back(mk(1, 42, 8'h33, 1));
        txq[1].push_back(mk(1, 43, 8'h44, 1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!p1_gnt && n < 50);
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL burst_start: p1 not granted within %0d cycles", n);
        end
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        wait_idle();
        check("burst_first_beat", 32'(mem[40]), 32'h11);
        check("rst_target_unchanged", 32'(mem[41]), 32'(pre41));

        // After reset, p0 wins the first tie.
        mark = trace.size();
        txq[0].push_back(mk(0, 40, 0, 0));
        txq[1].push_back(mk(0, 40, 0, 0));
        wait_idle();
        exp_q = {1, 2};
        check_seq("tie_after_rst", mark, exp_q);
        check("p1_rd_after_rst", 32'(p1_rdata), 32'h11);

        check("sb_drained", sbq[0].size() + sbq[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
